// File: rtl/ysyx_25010008_mem_pkg.sv
// Shared definitions for the IFU/LSU memory arbiter.
// Contents:
//   arb_state_e           - arbiter FSM states (IDLE/REQ/WAIT/RESP)
//   OWNER_IFU / OWNER_LSU - encodings of the owner output and last-grant value
//   AW_DEFAULT/DW_DEFAULT - default address and data widths
package ysyx_25010008_mem_pkg;

    localparam int unsigned AW_DEFAULT = 32;
    localparam int unsigned DW_DEFAULT = 32;

    localparam logic OWNER_IFU = 1'b0;
    localparam logic OWNER_LSU = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } arb_state_e;

endpackage

// File: rtl/ysyx_25010008_arb_pick.sv
// Combinational winner selection between IFU and LSU.
// Build option: YSYX_25010008_ARB_RR_EN
//   defined   - round-robin: on a tie the requester not granted last wins
//   undefined - fixed priority, LSU over IFU (last_owner is not used)
// Ports:
//   ifu_valid  in  IFU request pending
//   lsu_valid  in  LSU request pending
//   last_owner in  owner of the most recent grant (OWNER_IFU/OWNER_LSU)
//   grant_ifu  out IFU wins this cycle
//   grant_lsu  out LSU wins this cycle
module ysyx_25010008_arb_pick
    import ysyx_25010008_mem_pkg::*;
(
    input  logic ifu_valid,
    input  logic lsu_valid,
    input  logic last_owner,
    output logic grant_ifu,
    output logic grant_lsu
);

`ifdef YSYX_25010008_ARB_RR_EN
    always_comb begin
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
        if (ifu_valid && lsu_valid) begin
            // Tie: hand the port to whoever did not have it last time.
            if (last_owner == OWNER_IFU) begin
                grant_lsu = 1'b1;
            end else begin
                grant_ifu = 1'b1;
            end
        end else begin
            grant_ifu = ifu_valid;
            grant_lsu = lsu_valid;
        end
    end
`else
    logic unused_last_owner;
    assign unused_last_owner = last_owner;

    assign grant_lsu = lsu_valid;
    assign grant_ifu = ifu_valid & ~lsu_valid;
`endif

endmodule

// File: rtl/ysyx_25010008_mem_arbiter.sv
// Shares one memory port between the instruction-fetch unit (IFU) and the
// load/store unit (LSU). One request is accepted at a time over valid/ready,
// latched, issued to memory, and the response is returned to its requester.
// Build option: YSYX_25010008_ARB_RR_EN selects round-robin arbitration
// (see ysyx_25010008_arb_pick); default is fixed LSU-over-IFU priority.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   ifu_req_valid/ready      IFU read request handshake, ifu_addr address
//   ifu_resp_valid/rdata     one-cycle fetch response pulse and held data
//   lsu_req_valid/ready      LSU request handshake
//   lsu_wen/addr/wdata/wmask LSU request fields (wen 1 = store)
//   lsu_resp_valid/rdata     one-cycle load/store response pulse and held data
//   mem_req_valid/ready      memory request handshake
//   mem_wen/addr/wdata/wmask latched request fields driven to memory
//   mem_resp_valid/rdata     memory response (single cycle)
//   owner                    current/last grant, 0 = IFU, 1 = LSU
module ysyx_25010008_mem_arbiter
    import ysyx_25010008_mem_pkg::*;
#(
    parameter int unsigned AW = AW_DEFAULT,
    parameter int unsigned DW = DW_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [AW-1:0]     ifu_addr,
    output logic              ifu_resp_valid,
    output logic [DW-1:0]     ifu_rdata,

    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic              lsu_wen,
    input  logic [AW-1:0]     lsu_addr,
    input  logic [DW-1:0]     lsu_wdata,
    input  logic [DW/8-1:0]   lsu_wmask,
    output logic              lsu_resp_valid,
    output logic [DW-1:0]     lsu_rdata,

    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_wen,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    output logic [DW/8-1:0]   mem_wmask,
    input  logic              mem_resp_valid,
    input  logic [DW-1:0]     mem_rdata,

    output logic              owner
);

    arb_state_e state_q, state_d;

    logic [AW-1:0]   addr_q,  addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW/8-1:0] wmask_q, wmask_d;
    logic            wen_q,   wen_d;
    logic            owner_q, owner_d;
    logic [DW-1:0]   ifu_rdata_q, ifu_rdata_d;
    logic [DW-1:0]   lsu_rdata_q, lsu_rdata_d;

    logic grant_ifu, grant_lsu;
    logic accept_ifu, accept_lsu;

    // The latched owner doubles as the last-grant register for round-robin.
    ysyx_25010008_arb_pick u_pick (
        .ifu_valid  (ifu_req_valid),
        .lsu_valid  (lsu_req_valid),
        .last_owner (owner_q),
        .grant_ifu  (grant_ifu),
        .grant_lsu  (grant_lsu)
    );

    assign accept_ifu = ifu_req_valid & ifu_req_ready;
    assign accept_lsu = lsu_req_valid & lsu_req_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept_ifu || accept_lsu) state_d = ST_REQ;
            ST_REQ:  if (mem_req_ready)            state_d = ST_WAIT;
            ST_WAIT: if (mem_resp_valid)           state_d = ST_RESP;
            ST_RESP:                               state_d = ST_IDLE;
            default:                               state_d = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        ifu_req_ready  = 1'b0;
        lsu_req_ready  = 1'b0;
        mem_req_valid  = 1'b0;
        ifu_resp_valid = 1'b0;
        lsu_resp_valid = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                ifu_req_ready = grant_ifu;
                lsu_req_ready = grant_lsu;
            end
            ST_REQ: begin
                mem_req_valid = 1'b1;
            end
            ST_RESP: begin
                ifu_resp_valid = (owner_q == OWNER_IFU);
                lsu_resp_valid = (owner_q == OWNER_LSU);
            end
            default: ;
        endcase
    end

    // Request latch and per-requester response capture
    always_comb begin
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wmask_d     = wmask_q;
        wen_d       = wen_q;
        owner_d     = owner_q;
        ifu_rdata_d = ifu_rdata_q;
        lsu_rdata_d = lsu_rdata_q;

        if (accept_lsu) begin
            addr_d  = lsu_addr;
            wdata_d = lsu_wdata;
            wmask_d = lsu_wmask;
            wen_d   = lsu_wen;
            owner_d = OWNER_LSU;
        end else if (accept_ifu) begin
            // Fetches are always reads: no write enable, no byte lanes.
            addr_d  = ifu_addr;
            wdata_d = '0;
            wmask_d = '0;
            wen_d   = 1'b0;
            owner_d = OWNER_IFU;
        end

        // A response is only meaningful while waiting for one.
        if (state_q == ST_WAIT && mem_resp_valid) begin
            if (owner_q == OWNER_IFU) begin
                ifu_rdata_d = mem_rdata;
            end else begin
                lsu_rdata_d = mem_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            wen_q       <= 1'b0;
            owner_q     <= OWNER_IFU;
            ifu_rdata_q <= '0;
            lsu_rdata_q <= '0;
        end else begin
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
            wen_q       <= wen_d;
            owner_q     <= owner_d;
            ifu_rdata_q <= ifu_rdata_d;
            lsu_rdata_q <= lsu_rdata_d;
        end
    end

    assign mem_wen   = wen_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wmask = wmask_q;
    assign ifu_rdata = ifu_rdata_q;
    assign lsu_rdata = lsu_rdata_q;
    assign owner     = owner_q;

endmodule

// File: tb/tb_ysyx_25010008_mem_arbiter.sv
// Self-checking bench for ysyx_25010008_mem_arbiter. Expected responses are
// queued when a request is accepted and compared when a response pulse appears.
module tb_ysyx_25010008_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [3:0]  lsu_wmask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;
    logic        owner;

    ysyx_25010008_mem_arbiter #(.AW(32), .DW(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .ifu_req_valid  (ifu_req_valid),
        .ifu_req_ready  (ifu_req_ready),
        .ifu_addr       (ifu_addr),
        .ifu_resp_valid (ifu_resp_valid),
        .ifu_rdata      (ifu_rdata),
        .lsu_req_valid  (lsu_req_valid),
        .lsu_req_ready  (lsu_req_ready),
        .lsu_wen        (lsu_wen),
        .lsu_addr       (lsu_addr),
        .lsu_wdata      (lsu_wdata),
        .lsu_wmask      (lsu_wmask),
        .lsu_resp_valid (lsu_resp_valid),
        .lsu_rdata      (lsu_rdata),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_wen        (mem_wen),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_wmask      (mem_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_rdata      (mem_rdata),
        .owner          (owner)
    );

    typedef struct {
        logic        own;
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    logic        grants[$];
    int unsigned tests = 0;
    int unsigned fails = 0;
    int unsigned cyc = 0;
    int unsigned n_acc = 0;
    int unsigned n_mreq = 0;
    int unsigned last_mresp_cyc = 0;
    int unsigned rdy_dly = 0;
    int unsigned rsp_dly = 1;
    int unsigned m_phase = 0;
    int unsigned m_wait = 0;
    int unsigned m_cnt = 0;
    logic [31:0] m_addr = '0;
    logic        inject_resp = 1'b0;
    logic [31:0] exp_ifu_rd = '0;
    logic [31:0] exp_lsu_rd = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0000_0413;
        return a ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Memory model: optional ready back-pressure, response rsp_dly cycles after ready.
    initial begin
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_rdata      = '0;
        forever begin
            @(posedge clk); #2;
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b0;
            if (rst) begin
                m_phase = 0;
                m_wait  = 0;
            end else if (inject_resp) begin
                mem_resp_valid = 1'b1;
                mem_rdata      = 32'hBAD0_BAD0;
            end else if (m_phase == 0) begin
                if (mem_req_valid) begin
                    if (m_wait >= rdy_dly) begin
                        mem_req_ready = 1'b1;
                        m_addr  = mem_addr;
                        m_phase = 1;
                        m_cnt   = 0;
                        m_wait  = 0;
                    end else begin
                        m_wait++;
                    end
                end
            end else begin
                m_cnt++;
                if (m_cnt >= rsp_dly) begin
                    mem_resp_valid = 1'b1;
                    mem_rdata      = mem_fn(m_addr);
                    m_phase        = 0;
                end
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                sb.delete();
                exp_ifu_rd = '0;
                exp_lsu_rd = '0;
            end else begin
                if (sb.size() != 0) begin
                    check_eq("rdy_busy", {ifu_req_ready, lsu_req_ready}, 2'b00);
                    if (mem_req_valid) begin
                        n_mreq++;
                        check_eq("mem_addr", mem_addr, sb[0].addr);
                        check_eq("mem_wen", mem_wen, sb[0].wen);
                        check_eq("mem_wmask", mem_wmask, sb[0].wmask);
                        if (sb[0].wen) check_eq("mem_wdata", mem_wdata, sb[0].wdata);
                    end
                end
                if (ifu_req_valid && lsu_req_valid)
                    check_eq("one_rdy", ifu_req_ready & lsu_req_ready, 1'b0);
                if (ifu_req_valid && ifu_req_ready) begin
                    e.own = 1'b0; e.addr = ifu_addr; e.wen = 1'b0;
                    e.wdata = '0; e.wmask = '0; e.rdata = mem_fn(ifu_addr);
                    sb.push_back(e);
                    grants.push_back(1'b0);
                    n_acc++;
                end
                if (lsu_req_valid && lsu_req_ready) begin
                    e.own = 1'b1; e.addr = lsu_addr; e.wen = lsu_wen;
                    e.wdata = lsu_wdata; e.wmask = lsu_wmask; e.rdata = mem_fn(lsu_addr);
                    sb.push_back(e);
                    grants.push_back(1'b1);
                    n_acc++;
                end
                if (mem_resp_valid) last_mresp_cyc = cyc;
                if (ifu_resp_valid || lsu_resp_valid) begin
                    if (sb.size() == 0) begin
                        check_eq("spurious_resp", {ifu_resp_valid, lsu_resp_valid}, 2'b00);
                    end else begin
                        e = sb.pop_front();
                        check_eq("resp_owner", {ifu_resp_valid, lsu_resp_valid},
                                 e.own ? 2'b01 : 2'b10);
                        check_eq("resp_lat", cyc - last_mresp_cyc, 1);
                        if (e.own) exp_lsu_rd = e.rdata;
                        else       exp_ifu_rd = e.rdata;
                        check_eq("ifu_rdata", ifu_rdata, exp_ifu_rd);
                        check_eq("lsu_rdata", lsu_rdata, exp_lsu_rd);
                    end
                end
            end
        end
    end

    task automatic ifu_req(input logic [31:0] a);
        @(posedge clk); #1;
        ifu_addr      = a;
        ifu_req_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ifu_req_ready) break;
        end
        check_eq("ifu_acc", ifu_req_ready, 1'b1);
        @(posedge clk); #1;
        ifu_req_valid = 1'b0;
    endtask

    task automatic lsu_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] m);
        @(posedge clk); #1;
        lsu_wen       = w;
        lsu_addr      = a;
        lsu_wdata     = d;
        lsu_wmask     = m;
        lsu_req_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (lsu_req_ready) break;
        end
        check_eq("lsu_acc", lsu_req_ready, 1'b1);
        @(posedge clk); #1;
        lsu_req_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (sb.size() == 0) break;
        end
        check_eq("drain", sb.size(), 0);
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_rdy"}, {ifu_req_ready, lsu_req_ready}, 2'b00);
        check_eq({tag, "_resp"}, {ifu_resp_valid, lsu_resp_valid}, 2'b00);
        check_eq({tag, "_mreq"}, {mem_req_valid, mem_wen, mem_wmask}, 6'd0);
        check_eq({tag, "_maddr"}, mem_addr, 32'd0);
        check_eq({tag, "_mwdata"}, mem_wdata, 32'd0);
        check_eq({tag, "_rdata"}, {ifu_rdata, lsu_rdata}, 64'd0);
        check_eq({tag, "_owner"}, owner, 1'b0);
    endtask

    initial begin
        int unsigned n0;
        rst = 1'b1;
        ifu_req_valid = 1'b0; ifu_addr = '0;
        lsu_req_valid = 1'b0; lsu_wen = 1'b0; lsu_addr = '0; lsu_wdata = '0; lsu_wmask = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // IFU-only read, zero-wait memory, cycle-exact timing
        @(posedge clk); #1;
        ifu_addr      = 32'h8000_0000;
        ifu_req_valid = 1'b1;
        @(negedge clk);
        check_eq("t1_rdy", {ifu_req_ready, lsu_req_ready}, 2'b10);
        check_eq("t1_mreq_t0", mem_req_valid, 1'b0);
        @(posedge clk); #1;
        ifu_req_valid = 1'b0;
        @(negedge clk);
        check_eq("t1_mreq_t1", mem_req_valid, 1'b1);
        @(negedge clk);
        check_eq("t1_resp_t2", ifu_resp_valid, 1'b0);
        @(negedge clk);
        check_eq("t1_resp_t3", {ifu_resp_valid, lsu_resp_valid}, 2'b10);
        check_eq("t1_rdata", ifu_rdata, 32'h0000_0413);
        @(negedge clk);
        check_eq("t1_resp_t4", ifu_resp_valid, 1'b0);
        wait_done();

        // LSU store held through 3 cycles of back-pressure
        rdy_dly = 3;
        n0 = n_mreq;
        lsu_req(1'b1, 32'h8000_0100, 32'hDEAD_BEEF, 4'b0011);
        wait_done();
        check_eq("st_mreq_cycles", n_mreq - n0, 4);
        check_eq("st_owner", owner, 1'b1);
        rdy_dly = 0;

        // LSU load with slow response; IFU raises and drops valid while busy
        rsp_dly = 5;
        n0 = n_acc;
        lsu_req(1'b0, 32'h8000_0040, 32'h0, 4'h0);
        ifu_addr      = 32'h8000_0ABC;
        ifu_req_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1 ifu_req_valid = 1'b0;
        wait_done();
        check_eq("bp_acc", n_acc - n0, 1);
        rsp_dly = 1;

        // IFU read, leaves IFU as last grant
        ifu_req(32'h8000_0004);
        wait_done();

        // Both requesters valid for four transactions
        @(posedge clk); #1;
        grants.delete();
        ifu_addr = 32'h8000_0200;
        lsu_addr = 32'h8000_0300; lsu_wen = 1'b0; lsu_wmask = '0;
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (grants.size() >= 4) break;
        end
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        check_eq("tie_count", grants.size(), 4);
        wait_done();
        if (grants.size() >= 4) begin
`ifdef YSYX_25010008_ARB_RR_EN
            check_eq("tie_order", {grants[0], grants[1], grants[2], grants[3]}, 4'b1010);
`else
            check_eq("tie_order", {grants[0], grants[1], grants[2], grants[3]}, 4'b1111);
`endif
        end

        // Reset while waiting on memory, late response afterwards
        rsp_dly = 20;
        lsu_req(1'b0, 32'h8000_0500, 32'h0, 4'h0);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (m_phase == 1) break;
        end
        check_eq("rst_in_wait", m_phase, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        inject_resp = 1'b1;
        @(negedge clk);
        check_zero("rst_wait");
        @(posedge clk); #1;
        inject_resp = 1'b0;
        @(negedge clk);
        check_eq("rst_late_resp", {ifu_resp_valid, lsu_resp_valid, mem_req_valid}, 3'b000);
        rsp_dly = 1;
        ifu_req(32'h8000_0010);
        wait_done();

        // Spurious memory response while idle
        n0 = n_acc;
        @(posedge clk); #1;
        inject_resp = 1'b1;
        @(posedge clk); #1;
        inject_resp = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("spur_mreq", mem_req_valid, 1'b0);
        check_eq("spur_acc", n_acc - n0, 0);
        check_eq("spur_ifu_rdata", ifu_rdata, mem_fn(32'h8000_0010));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ysyx_25010008_mem_arbiter.md
# ysyx_25010008_mem_arbiter

Shares the core's single memory port between the instruction-fetch unit and the load/store unit. Accepts one request at a time from either requester over a valid/ready handshake and latches it. It then drives it to memory, waits for the memory response and returns the response to the originating requester. It sits between IFU/LSU and the memory/bus interface of the NPC, so both units operate on one physical port.

## Interface
- AW, 32, address width
- DW, 32, data width; write mask width is DW/8
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- ifu_req_valid  in  1  IFU read request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_addr  in  AW  fetch address
- ifu_resp_valid  out  1  one-cycle pulse, fetch data valid
- ifu_rdata  out  DW  fetch data
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_wen  in  1  1 = write, 0 = read
- lsu_addr  in  AW  load/store address
- lsu_wdata  in  DW  store data
- lsu_wmask  in  DW/8  byte-enable mask for stores
- lsu_resp_valid  out  1  one-cycle pulse, load data valid or store done
- lsu_rdata  out  DW  load data
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_wen, mem_addr, mem_wdata, mem_wmask  out  1/AW/DW/DW/8  latched request fields
- mem_resp_valid  in  1  memory response, one cycle
- mem_rdata  in  DW  memory read data
- owner  out  1  current/last grant: 0 = IFU, 1 = LSU

## Operation
- FSM states:
  - IDLE → REQ: on an accept.
  - REQ → WAIT: when mem_req_ready.
  - WAIT → RESP: when mem_resp_valid.
  - RESP → IDLE: unconditionally.
- Grant happens only in IDLE. The winner's req_ready is driven high combinationally in the same cycle its valid is high; the loser's ready stays 0.
- Accept = req_valid & req_ready. On accept the arbiter:
  - latches addr, wdata, wmask, wen and owner;
  - for IFU, forces wen = 0 and wmask = 0.
- REQ: mem_req_valid = 1. The mem_* fields hold stable until mem_req_ready is sampled high.
- WAIT: captures mem_rdata on mem_resp_valid into the response register of the owner.
- RESP: pulses exactly one resp_valid, to the owner only. Writes also get a response; lsu_rdata then carries the captured mem_rdata, and its value is don't-care.
- rdata outputs hold their value until the next response to that requester.
- Ignored inputs:
  - mem_resp_valid outside WAIT;
  - mem_req_ready outside REQ.
- A requester may drop valid before accept; no grant results and no state changes.
- Reset mid-transaction forces IDLE and clears all outputs. A late memory response is ignored.

## Timing
- Reset values: all ready/valid outputs 0, mem_* outputs 0, ifu_rdata = lsu_rdata = 0, owner = 0, state IDLE.
- Request accepted at cycle t → mem_req_valid at t+1.
- Zero-wait memory (ready at t+1, resp at t+2) → requester resp_valid at t+3 → next accept possible at t+4.
- One transaction in flight at most. req_ready is never asserted outside IDLE.

## Configuration
- YSYX_25010008_ARB_RR_EN defined: round-robin arbitration.
  - When both requesters are valid in IDLE, the one not granted last wins.
  - A single valid requester always wins.
  - The last-grant register resets to IFU, so LSU wins the first tie.
- Undefined: fixed priority, LSU over IFU. No last-grant register.

## Structure
- Package ysyx_25010008_mem_pkg holds:
  - the FSM state enum (IDLE/REQ/WAIT/RESP);
  - owner encodings OWNER_IFU = 0, OWNER_LSU = 1;
  - AW/DW defaults.
- One sub-module, ysyx_25010008_arb_pick, is combinational winner selection. Inputs: ifu_valid, lsu_valid, last owner. Outputs: grant_ifu, grant_lsu. It contains the macro-dependent logic.

## Test plan
- IFU-only read: ifu_addr = 0x8000_0000, memory zero-wait returning 0x0000_0413 → ifu_req_ready at t, mem_req_valid at t+1, ifu_resp_valid = 1 with ifu_rdata = 0x0000_0413 at t+3; lsu_resp_valid stays 0.
- LSU store: addr 0x8000_0100, wdata 0xDEAD_BEEF, wmask 4'b0011 → mem_wen = 1 with the same fields held through 3 cycles of mem_req_ready = 0; one lsu_resp_valid pulse after mem_resp_valid.
- Simultaneous requests, both valid for 4 transactions:
  - RR: grants LSU, IFU, LSU, IFU;
  - fixed: LSU ×4 while lsu_req_valid stays high.
- Backpressure/latency: mem_resp_valid 5 cycles after accept by memory → resp_valid exactly 1 cycle later, single pulse; no req_ready asserted meanwhile.
- Reset in WAIT, then mem_resp_valid the next cycle → no resp_valid pulse, all outputs 0, state IDLE; the next IFU request completes normally.
- Spurious mem_resp_valid in IDLE and a requester dropping valid without ready → no response, no state change.
